// File: rtl/fsm_timer_responder.sv
// Responder FSM: accepts START, counts DURATION cycles, then holds READY until RESET.
// Moore outputs from registered state/counter; START ignored outside IDLE.
module fsm_timer_responder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             N_RESET,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DURATION,
    output logic             READY,
    output logic             BUSY,
    output logic [WIDTH-1:0] REMAIN
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_RUN  = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (RESET) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        if (DURATION != '0) begin
                            w_state_nxt = S_RUN;
                            w_cnt_nxt   = DURATION;
                        end else begin
                            w_state_nxt = S_DONE;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
                S_RUN: begin
                    // cnt of 0 in RUN is unreachable; retiring it to DONE avoids any wrap
                    if (r_cnt > WIDTH'(1)) begin
                        w_cnt_nxt = r_cnt - WIDTH'(1);
                    end else begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = '0;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign READY  = (r_state == S_DONE);
    assign BUSY   = (r_state == S_RUN);
    assign REMAIN = r_cnt;

endmodule

// File: tb/tb_fsm_timer_responder.sv
// Scoreboard bench: each driven cycle pushes the expected {READY,BUSY,REMAIN} after the next edge.
module tb_fsm_timer_responder;

    logic       CLK;
    logic       N_RESET;
    logic       RESET;
    logic       START;
    logic [7:0] DURATION;
    logic       READY;
    logic       BUSY;
    logic [7:0] REMAIN;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    fsm_timer_responder #(.WIDTH(8)) dut (
        .CLK      (CLK),
        .N_RESET  (N_RESET),
        .RESET    (RESET),
        .START    (START),
        .DURATION (DURATION),
        .READY    (READY),
        .BUSY     (BUSY),
        .REMAIN   (REMAIN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] e(input logic rdy, input logic bsy, input logic [7:0] rem);
        return {rdy, bsy, rem};
    endfunction

    // Drive one cycle of inputs away from the edge and queue what must appear after that edge.
    task automatic drive(input string tag, input logic st, input logic rst,
                         input logic [7:0] dur, input logic [9:0] exp);
        @(negedge CLK);
        START    = st;
        RESET    = rst;
        DURATION = dur;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic idle(input string tag, input int n, input logic [9:0] exp);
        for (int i = 0; i < n; i++)
            drive(tag, 1'b0, 1'b0, 8'($urandom_range(0, 255)), exp);
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                check(tag_q.pop_front(), {22'd0, READY, BUSY, REMAIN}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        N_RESET  = 1'b0;
        RESET    = 1'b0;
        START    = 1'b0;
        DURATION = 8'd0;
        #3;
        check("reset_outputs", {22'd0, READY, BUSY, REMAIN}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        N_RESET = 1'b1;

        idle("post_reset_idle", 2, e(0, 0, 0));

        // basic handshake, DURATION=3
        drive("basic_e0", 1, 0, 8'd3, e(0, 1, 3));
        drive("basic_e1", 0, 0, 8'd77, e(0, 1, 2));
        drive("basic_e2", 0, 0, 8'd0, e(0, 1, 1));
        drive("basic_e3", 0, 0, 8'd5, e(1, 0, 0));
        idle("basic_hold", 10, e(1, 0, 0));
        drive("basic_clear", 0, 1, 8'd0, e(0, 0, 0));
        idle("basic_idle", 2, e(0, 0, 0));

        // zero duration
        drive("zero_e0", 1, 0, 8'd0, e(1, 0, 0));
        idle("zero_hold", 3, e(1, 0, 0));
        drive("zero_clear", 0, 1, 8'd0, e(0, 0, 0));

        // START ignored while running and while done
        drive("ign_e0", 1, 0, 8'd4, e(0, 1, 4));
        drive("ign_e1", 0, 0, 8'd0, e(0, 1, 3));
        drive("ign_e2_start", 1, 0, 8'd9, e(0, 1, 2));
        drive("ign_e3", 0, 0, 8'd9, e(0, 1, 1));
        drive("ign_e4", 0, 0, 8'd9, e(1, 0, 0));
        drive("ign_done_start", 1, 0, 8'd9, e(1, 0, 0));
        drive("ign_done_start0", 1, 0, 8'd0, e(1, 0, 0));
        idle("ign_done_hold", 2, e(1, 0, 0));
        drive("ign_clear", 0, 1, 8'd0, e(0, 0, 0));

        // priority: RESET beats START in IDLE, and RESET aborts RUN
        drive("prio_rst_start", 1, 1, 8'd5, e(0, 0, 0));
        idle("prio_idle", 1, e(0, 0, 0));
        drive("prio_run_e0", 1, 0, 8'd8, e(0, 1, 8));
        drive("prio_run_e1", 0, 0, 8'd8, e(0, 1, 7));
        drive("prio_run_e2", 0, 0, 8'd8, e(0, 1, 6));
        drive("prio_abort", 1, 1, 8'd8, e(0, 0, 0));
        drive("prio_restart", 1, 0, 8'd2, e(0, 1, 2));
        drive("prio_restart_e1", 0, 0, 8'd0, e(0, 1, 1));
        drive("prio_restart_e2", 0, 0, 8'd0, e(1, 0, 0));
        drive("prio_clear", 0, 1, 8'd0, e(0, 0, 0));

        // RESET held high with START toggling
        for (int i = 0; i < 4; i++)
            drive("rst_held", 1'(i), 1, 8'(i + 1), e(0, 0, 0));

        // asynchronous reset in the middle of RUN at REMAIN=5
        drive("async_e0", 1, 0, 8'd8, e(0, 1, 8));
        drive("async_e1", 0, 0, 8'd8, e(0, 1, 7));
        drive("async_e2", 0, 0, 8'd8, e(0, 1, 6));
        drive("async_e3", 0, 0, 8'd8, e(0, 1, 5));
        @(negedge CLK);
        START   = 1'b0;
        RESET   = 1'b0;
        #2;
        N_RESET = 1'b0;
        #1;
        check("async_clear", {22'd0, READY, BUSY, REMAIN}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        N_RESET = 1'b1;
        idle("async_post_idle", 3, e(0, 0, 0));

        // maximum count, no wrap
        drive("max_e0", 1, 0, 8'd255, e(0, 1, 255));
        for (int k = 1; k < 255; k++)
            drive("max_run", 0, 0, 8'($urandom_range(0, 255)), e(0, 1, 8'(255 - k)));
        drive("max_done", 0, 0, 8'd0, e(1, 0, 0));
        idle("max_hold", 3, e(1, 0, 0));
        drive("max_clear", 0, 1, 8'd0, e(0, 0, 0));

        begin : drain
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(negedge CLK);
                budget--;
            end
            if (exp_q.size() > 0)
                check("drain_timeout", 32'(exp_q.size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
